// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response handshake bundle between datapath (master) and data memory (slave)
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: big-endian byte-addressed data memory with wait states; MEM_PERF_COUNT_EN adds perf counters
module data_mem_responder #(
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_STATES = 2
) (
  input logic clk,
  input logic rst,
  data_mem_responder_if.slave bus
`ifdef MEM_PERF_COUNT_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_stall
`endif
);
  localparam int AW = $clog2(DEPTH_BYTES);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        accept, commit, done, bad, c_write;
  logic [31:0] c_addr, c_wdata, load_data;
  logic [3:0]  c_be;
  logic [AW-1:0] idx;
  logic [7:0]  mem [DEPTH_BYTES] = '{default: 8'h00};
  // With zero wait states the commit happens on the accept edge, so use the live request
  always_comb begin
    accept    = state_q == IDLE && req_ready_q && bus.req_valid;
    c_write   = state_q == IDLE ? bus.req_write : write_q;
    c_addr    = state_q == IDLE ? bus.req_addr : addr_q;
    c_wdata   = state_q == IDLE ? bus.req_wdata : wdata_q;
    c_be      = state_q == IDLE ? bus.req_be : be_q;
    commit    = (state_q == BUSY && cnt_q == 4'd0) || (accept && WAIT_STATES == 0);
    done      = state_q == RESP && bus.resp_ready;
    bad       = c_addr[1:0] != 2'b00 || c_addr > 32'(DEPTH_BYTES - 4);
    idx       = c_addr[AW-1:0];
    load_data = {mem[idx], mem[idx + AW'(1)], mem[idx + AW'(2)], mem[idx + AW'(3)]};
    state_d   = commit ? RESP : accept ? BUSY : done ? IDLE : state_q;
    cnt_d     = accept ? 4'(WAIT_STATES - 1) : state_q == BUSY ? cnt_q - 4'd1 : cnt_q;
    write_d   = accept ? bus.req_write : write_q;
    addr_d    = accept ? bus.req_addr : addr_q;
    wdata_d   = accept ? bus.req_wdata : wdata_q;
    be_d      = accept ? bus.req_be : be_q;
    req_ready_d  = state_d == IDLE;
    resp_valid_d = state_d == RESP;
    rdata_d   = commit ? ((c_write || bad) ? 32'h0 : load_data) : done ? 32'h0 : rdata_q;
    err_d     = commit ? bad : done ? 1'b0 : err_q;
  end
`ifdef MEM_PERF_COUNT_EN
  logic [31:0] loads_q, loads_d, stores_q, stores_d, stall_q, stall_d;
  always_comb begin
    loads_d  = loads_q + 32'(done && !write_q);
    stores_d = stores_q + 32'(done && write_q);
    stall_d  = stall_q + 32'(resp_valid_q && !bus.resp_ready);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      loads_q  <= '0;
      stores_q <= '0;
      stall_q  <= '0;
    end else begin
      loads_q  <= loads_d;
      stores_q <= stores_d;
      stall_q  <= stall_d;
    end
  assign perf_loads  = loads_q;
  assign perf_stores = stores_q;
  assign perf_stall  = stall_q;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  // Storage is never reset; a reset only prevents the commit by forcing IDLE
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (commit && c_write && !bad && c_be[3-i]) mem[idx + AW'(i)] <= c_wdata[31-8*i -: 8];
  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of the data memory responder at WAIT_STATES=2 and WAIT_STATES=0
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  data_mem_responder_if i0 ();
  data_mem_responder_if i1 ();
  logic [1:0]  rv, rw, rr;
  logic [31:0] ra [2];
  logic [31:0] rwd [2];
  logic [3:0]  rbe [2];
  logic [1:0]  ov, ordy, oe;
  logic [31:0] od [2];
  assign i0.req_valid = rv[0];
  assign i0.req_write = rw[0];
  assign i0.req_addr = ra[0];
  assign i0.req_wdata = rwd[0];
  assign i0.req_be = rbe[0];
  assign i0.resp_ready = rr[0];
  assign i1.req_valid = rv[1];
  assign i1.req_write = rw[1];
  assign i1.req_addr = ra[1];
  assign i1.req_wdata = rwd[1];
  assign i1.req_be = rbe[1];
  assign i1.resp_ready = rr[1];
  assign ov = {i1.resp_valid, i0.resp_valid};
  assign ordy = {i1.req_ready, i0.req_ready};
  assign oe = {i1.resp_err, i0.resp_err};
  assign od[0] = i0.resp_rdata;
  assign od[1] = i1.resp_rdata;
`ifdef MEM_PERF_COUNT_EN
  logic [31:0] pl0, ps0, pst0, pl1, ps1, pst1;
`endif
  data_mem_responder #(.DEPTH_BYTES(1024), .WAIT_STATES(2)) u0 (
    .clk(clk), .rst(rst), .bus(i0)
`ifdef MEM_PERF_COUNT_EN
    , .perf_loads(pl0), .perf_stores(ps0), .perf_stall(pst0)
`endif
  );
  data_mem_responder #(.DEPTH_BYTES(1024), .WAIT_STATES(0)) u1 (
    .clk(clk), .rst(rst), .bus(i1)
`ifdef MEM_PERF_COUNT_EN
    , .perf_loads(pl1), .perf_stores(ps1), .perf_stall(pst1)
`endif
  );
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic xact(input int s, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input int stall, input logic [31:0] exp_rd,
                      input logic exp_err, input string tag);
    int lat = 0;
    int w = 0;
    @(negedge clk);
    while (!ordy[s] && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " req_ready"}, 64'(ordy[s]), 64'd1);
    rv[s] = 1'b1; rw[s] = wr; ra[s] = a; rwd[s] = wd; rbe[s] = be; rr[s] = (stall == 0);
    @(posedge clk);
    #1 rv[s] = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ov[s] && lat < 40);
    chk({tag, " latency"}, 64'(lat), (s == 1) ? 64'd1 : 64'd3);
    chk({tag, " rdata"}, 64'(od[s]), 64'(exp_rd));
    chk({tag, " err"}, 64'(oe[s]), 64'(exp_err));
    for (int i = 0; i < stall; i++) begin
      chk({tag, " hold"}, {29'd0, ov[s], oe[s], ordy[s], od[s]}, {29'd0, 1'b1, exp_err, 1'b0, exp_rd});
      rv[s] = i[0]; rw[s] = 1'b1; ra[s] = 32'h10; rwd[s] = 32'h0; rbe[s] = 4'hF;
      @(negedge clk);
    end
    rv[s] = 1'b0;
    rr[s] = 1'b1;
    @(negedge clk);
    chk({tag, " release"}, {29'd0, ov[s], oe[s], ordy[s], od[s]}, {29'd0, 1'b0, 1'b0, 1'b1, 32'h0});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    rv = '0; rw = '0; rr = '0;
    for (int i = 0; i < 2; i++) begin
      ra[i] = '0; rwd[i] = '0; rbe[i] = '0;
    end
    #2 rst = 1'b0;
    #1 chk("reset u0", {29'd0, ordy[0], ov[0], oe[0], od[0]}, 64'd0);
    chk("reset u1", {29'd0, ordy[1], ov[1], oe[1], od[1]}, 64'd0);
    @(negedge clk) rst = 1'b1;
    chk("ready before edge", 64'(ordy[0]), 64'd0);
    @(negedge clk);
    chk("ready after edge", 64'(ordy[0]), 64'd1);
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, "store");
    chk("mem 0x10", 64'(u0.mem[16]), 64'hDE);
    chk("mem 0x13", 64'(u0.mem[19]), 64'hEF);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, 1'b0, "load");
    xact(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 0, 32'h0, 1'b0, "be store");
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDE22BE44, 1'b0, "be load");
    xact(0, 1'b0, 32'h12, 32'h0, 4'h0, 0, 32'h0, 1'b1, "misaligned");
    xact(0, 1'b1, 32'h3FE, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1'b1, "range store");
    chk("range mem top", {32'd0, u0.mem[1020], u0.mem[1021], u0.mem[1022], u0.mem[1023]}, 64'd0);
    xact(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 0, 32'h0, 1'b0, "top word");
    xact(0, 1'b0, 32'h410, 32'h0, 4'h0, 0, 32'h0, 1'b1, "alias");
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, 32'hDE22BE44, 1'b0, "backpressure");
    xact(0, 1'b1, 32'h10, 32'h0, 4'h0, 0, 32'h0, 1'b0, "be zero store");
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDE22BE44, 1'b0, "be zero load");
    @(negedge clk);
    rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h20; rwd[0] = 32'hCAFEF00D; rbe[0] = 4'hF; rr[0] = 1'b1;
    @(posedge clk);
    #1 rv[0] = 1'b0;
    #2 rst = 1'b0;
    #1 chk("reset busy", {29'd0, ordy[0], ov[0], oe[0], od[0]}, 64'd0);
    @(negedge clk) rst = 1'b1;
    xact(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'h0, 1'b0, "after reset");
    xact(1, 1'b1, 32'h40, 32'h12345678, 4'hF, 0, 32'h0, 1'b0, "ws0 store");
    xact(1, 1'b0, 32'h40, 32'h0, 4'h0, 0, 32'h12345678, 1'b0, "ws0 load");
    xact(1, 1'b1, 32'h44, 32'hA5A5A5A5, 4'b1000, 4, 32'h0, 1'b0, "ws0 stalled store");
    xact(1, 1'b0, 32'h44, 32'h0, 4'h0, 0, 32'hA5000000, 1'b0, "ws0 load2");
    xact(1, 1'b0, 32'h42, 32'h0, 4'h0, 0, 32'h0, 1'b1, "ws0 err load");
`ifdef MEM_PERF_COUNT_EN
    chk("perf loads", 64'(pl1), 64'd3);
    chk("perf stores", 64'(ps1), 64'd2);
    chk("perf stall", 64'(pst1), 64'd4);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the datapath's load/store port: a byte-addressed, big-endian data memory.
- Accepts one word request at a time over a valid/ready handshake.
- Inserts a programmable number of wait states, then returns a response over a second valid/ready handshake.
- Replaces the zero-latency data memory when the datapath is built multi-cycle or stall-aware.

Parameters:
DEPTH_BYTES, 1024, size of the byte array; addresses at or above this are out of range
WAIT_STATES, 2, number of BUSY cycles between request accept and response (0..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_addr  input  32  byte address (word-aligned required)
req_wdata  input  32  store data; bits [31:24] go to addr+0
req_be  input  4  store byte enables; be[3] covers addr+0, be[0] covers addr+3
resp_valid  output  1  response present
resp_ready  input  1  datapath accepts the response
resp_rdata  output  32  load data, big-endian; 0 for stores and errors
resp_err  output  1  misaligned or out-of-range access

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
  - Memory contents are not cleared; the array is zero-filled at time 0.
- One clock after reset deasserts, req_ready=1.
- States:
  - IDLE: req_ready=1, resp_valid=0.
    - Accept when req_valid & req_ready on a rising edge. Capture write, addr, wdata, be.
    - Go to BUSY with counter=WAIT_STATES-1, or go directly to RESP if WAIT_STATES=0.
  - BUSY: req_ready=0.
    - Counter decrements each cycle; at 0 the next edge goes to RESP.
  - Transition into RESP (the commit edge):
    - Error check: captured addr[1:0]!=0 or addr>DEPTH_BYTES-4 sets resp_err=1, resp_rdata=0, no memory write.
    - Store: write each byte whose be bit is set; resp_rdata=0.
    - Load: resp_rdata = {mem[a],mem[a+1],mem[a+2],mem[a+3]}.
  - RESP: resp_valid=1, req_ready=0. Outputs hold stable until resp_valid & resp_ready. That edge returns to IDLE and clears resp_valid, resp_rdata and resp_err.
- Latency: resp_valid rises exactly WAIT_STATES+1 cycles after the accept edge.
- Throughput: at most one request per WAIT_STATES+2 cycles. There is no back-to-back accept in the RESP exit cycle.
- req_valid while req_ready=0 is ignored. The datapath must hold the request until it is accepted.
- resp_ready held high before resp_valid rises: the response is consumed on its first valid cycle.
- A store with be=4'b0000 completes normally and modifies nothing.
- Reset during BUSY aborts the request and no write occurs. Reset in RESP drops the response; the store already committed stays.
- Address bits above log2(DEPTH_BYTES) are used only in the range check; they do not alias.

Optional Feature:
- Macro: MEM_PERF_COUNT_EN.
- When defined, adds three outputs:
  - perf_loads (32 bits): increments on every load response handshake.
  - perf_stores (32 bits): increments on every store response handshake.
  - perf_stall (32 bits): increments on every cycle with resp_valid=1 and resp_ready=0.
- All three reset to 0 and wrap at 2^32; error responses are counted too.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Store then load, WAIT_STATES=2: store addr=0x10, wdata=0xDEADBEEF, be=4'hF, resp_ready=1.
  - resp_valid rises 3 cycles after accept, resp_err=0.
  - A load at 0x10 returns 0xDEADBEEF; mem[0x10]=0xDE, mem[0x13]=0xEF.
- Byte enables: with 0xDEADBEEF at 0x10, store wdata=0x11223344, be=4'b0101.
  - A load at 0x10 returns 0xDE22BE44.
- Errors: load addr=0x12 gives resp_err=1, rdata=0.
  - Store addr=0x3FE (DEPTH_BYTES=1024) gives resp_err=1 and no byte of memory changes.
- Response backpressure: a load is completed with resp_ready held 0 for 5 cycles.
  - resp_valid, rdata and err stay stable; req_ready stays 0.
  - req_valid pulses during that time are ignored. Handshake on cycle 6, then IDLE.
- Reset mid-operation: assert rst=0 asynchronously during BUSY of a store to 0x20 with wdata=0xCAFEF00D.
  - All outputs go to 0 immediately; a later load at 0x20 returns the old value 0x00000000.
- WAIT_STATES=0 and MEM_PERF_COUNT_EN: run 3 loads and 2 stores, one store stalled 4 cycles.
  - Each resp_valid arrives 1 cycle after accept.
  - perf_loads=3, perf_stores=2, perf_stall=4.
